// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the memory-stage load/store unit.
//   - funct3 width/sign codes for RV32I loads and stores
//   - lsu_state_t: transaction FSM states
//   - wstrb_shift: positions a byte-enable pattern at the access offset
//   - access_bad: flags illegal funct3 and misaligned accesses
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] wstrb_shift(input logic [3:0] base, input logic [1:0] ofs);
        return base << ofs;
    endfunction

    // Unsigned variants exist only for loads; halves and words must be naturally aligned.
    function automatic logic access_bad(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic b;
        case (f3)
            F3_B:    b = 1'b0;
            F3_H:    b = lo[0];
            F3_W:    b = (lo != 2'b00);
            F3_BU:   b = is_store;
            F3_HU:   b = is_store | lo[0];
            default: b = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// load_extend: selects the addressed byte/half/word of a read word and
// sign- or zero-extends it to 32 bits.
//   rdata   in  32  word returned by the bus
//   addr_lo in   2  byte offset of the access
//   funct3  in   3  width/sign code
//   result  out 32  extended load value
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit. Converts one load/store per
// instruction into a single-outstanding req/gnt/rvalid bus transaction and
// stalls the pipeline while it is in flight.
//   clk, rst (sync, active-high)
//   mem_read, mem_write, funct3, alu_out, rs2_data : memory-stage instruction
//   data_memory_output : registered, extended load result
//   stall_mem          : freeze PC / pipeline registers
//   mem_fault          : one-cycle pulse on misalign, illegal funct3, timeout
//   bus_req/gnt/we/addr/wdata/wstrb/rvalid/rdata : data-memory bus
//
// state   | meaning
// IDLE    | waiting for an access; decodes and validates it
// REQ     | bus_req high with latched fields, waiting for bus_gnt
// WAIT    | request accepted, waiting for bus_rvalid
// DONE    | result valid, pipeline advances; inputs ignored
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    output logic [31:0] data_memory_output,
    output logic        stall_mem,
    output logic        mem_fault,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    lsu_state_t  state;
    logic [CW-1:0] tmo_cnt;
    logic [1:0]  req_lo;
    logic [2:0]  req_f3;
    logic        access;
    logic        bad;
    logic        accept;
    logic        tmo_hit;
    logic [31:0] load_val;
    logic [31:0] next_wdata;
    logic [3:0]  next_wstrb;

    assign access    = mem_read | mem_write;
    assign bad       = access_bad(mem_write, funct3, alu_out[1:0]);
    assign accept    = (state == ST_IDLE) && access && !bad;
    assign stall_mem = accept || (state == ST_REQ) || (state == ST_WAIT);
    assign bus_req   = (state == ST_REQ);
    assign tmo_hit   = (tmo_cnt == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        case (funct3)
            F3_B:    next_wdata = {4{rs2_data[7:0]}};
            F3_H:    next_wdata = {2{rs2_data[15:0]}};
            default: next_wdata = rs2_data;
        endcase
        if (!mem_write) begin
            next_wstrb = 4'b0000;
        end else begin
            case (funct3)
                F3_B:    next_wstrb = wstrb_shift(4'b0001, alu_out[1:0]);
                F3_H:    next_wstrb = wstrb_shift(4'b0011, alu_out[1:0]);
                default: next_wstrb = 4'b1111;
            endcase
        end
    end

    load_extend u_load_extend (
        .rdata   (bus_rdata),
        .addr_lo (req_lo),
        .funct3  (req_f3),
        .result  (load_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            tmo_cnt            <= '0;
            req_lo             <= '0;
            req_f3             <= '0;
            bus_we             <= 1'b0;
            bus_addr           <= '0;
            bus_wdata          <= '0;
            bus_wstrb          <= '0;
            data_memory_output <= '0;
            mem_fault          <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (bad) begin
                            mem_fault          <= 1'b1;
                            data_memory_output <= '0;
                        end else begin
                            state     <= ST_REQ;
                            tmo_cnt   <= '0;
                            req_lo    <= alu_out[1:0];
                            req_f3    <= funct3;
                            bus_we    <= mem_write;
                            bus_addr  <= {alu_out[31:2], 2'b00};
                            bus_wdata <= next_wdata;
                            bus_wstrb <= next_wstrb;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    // A grant in REQ wins even if rvalid shows up in the same cycle;
                    // the response is only taken in WAIT.
                    if (state == ST_REQ && bus_gnt) begin
                        state <= ST_WAIT;
                    end else if (state == ST_WAIT && bus_rvalid) begin
                        state <= ST_DONE;
                        if (!bus_we) begin
                            data_memory_output <= load_val;
                        end
                    end else if (tmo_hit) begin
                        state              <= ST_DONE;
                        mem_fault          <= 1'b1;
                        data_memory_output <= '0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a queue-based scoreboard for the
// load/store unit. A bus responder grants and answers with programmable delays.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu_out = 32'h0;
    logic [31:0] rs2_data = 32'h0;
    logic [31:0] data_memory_output;
    logic        stall_mem;
    logic        mem_fault;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYC(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .funct3             (funct3),
        .alu_out            (alu_out),
        .rs2_data           (rs2_data),
        .data_memory_output (data_memory_output),
        .stall_mem          (stall_mem),
        .mem_fault          (mem_fault),
        .bus_req            (bus_req),
        .bus_gnt            (bus_gnt),
        .bus_we             (bus_we),
        .bus_addr           (bus_addr),
        .bus_wdata          (bus_wdata),
        .bus_wstrb          (bus_wstrb),
        .bus_rvalid         (bus_rvalid),
        .bus_rdata          (bus_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] dout;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    tests = 0;
    int    fails = 0;

    int          gnt_wait = 0;
    int          rv_wait = 0;
    bit          rv_with_gnt = 1'b0;
    bit          bus_manual = 1'b0;
    logic [31:0] model_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Bus responder: decides gnt/rvalid for the upcoming edge at each negedge.
    initial begin : bus_model
        int req_cnt;
        int rv_cnt;
        bit pending;
        req_cnt = 0;
        rv_cnt  = 0;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || stall_mem !== 1'b1) begin
                pending = 1'b0;
                req_cnt = 0;
            end
            if (!bus_manual) begin
                bus_gnt    = 1'b0;
                bus_rvalid = 1'b0;
                bus_rdata  = 32'hA5A5A5A5;
                if (!rst && bus_req === 1'b1) begin
                    if (req_cnt == gnt_wait) begin
                        bus_gnt    = 1'b1;
                        bus_rvalid = rv_with_gnt;
                        pending    = 1'b1;
                        rv_cnt     = 0;
                        req_cnt    = 0;
                    end else begin
                        req_cnt++;
                    end
                end else if (!rst && pending && stall_mem === 1'b1) begin
                    if (rv_cnt == rv_wait) begin
                        bus_rvalid = 1'b1;
                        bus_rdata  = model_rdata;
                        pending    = 1'b0;
                    end else begin
                        rv_cnt++;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations when a request is granted or an access completes.
    initial begin : monitor
        logic  prev_stall;
        req_t  er;
        done_t ed;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (bus_req === 1'b1 && bus_gnt === 1'b1) begin
                    if (req_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL req_unexpected got addr=%h exp none", bus_addr);
                    end else begin
                        er = req_q.pop_front();
                        check("req_addr", bus_addr, er.addr);
                        check("req_we", {31'h0, bus_we}, {31'h0, er.we});
                        check("req_wstrb", {28'h0, bus_wstrb}, {28'h0, er.wstrb});
                        check("req_wdata", bus_wdata, er.wdata);
                    end
                end
                if (mem_fault === 1'b1 || (prev_stall && stall_mem === 1'b0)) begin
                    if (done_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL done_unexpected got fault=%b dout=%h exp none",
                                 mem_fault, data_memory_output);
                    end else begin
                        ed = done_q.pop_front();
                        check("done_fault", {31'h0, mem_fault}, {31'h0, ed.fault});
                        check("done_dout", data_memory_output, ed.dout);
                    end
                end
            end
            prev_stall = (stall_mem === 1'b1);
        end
    end

    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [31:0] rdata,
                              input int gw, input int rw, input int exp_stall,
                              input logic exp_fault, input logic [31:0] exp_dout,
                              input logic [31:0] exp_baddr, input logic [3:0] exp_wstrb,
                              input logic [31:0] exp_wdata);
        int n;
        bit saw_req;
        gnt_wait    = gw;
        rv_wait     = rw;
        model_rdata = rdata;
        if (exp_stall != 0 && gw < 1000)
            req_q.push_back('{addr: exp_baddr, we: wr, wstrb: exp_wstrb, wdata: exp_wdata});
        done_q.push_back('{fault: exp_fault, dout: exp_dout});
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        alu_out   = addr;
        rs2_data  = rs2;
        n       = 0;
        saw_req = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (bus_req === 1'b1) saw_req = 1'b1;
            if (stall_mem !== 1'b1) break;
            n++;
            if (n >= 200) break;
        end
        check({name, " stall_cycles"}, n, exp_stall);
        check({name, " bus_req_seen"}, {31'h0, saw_req}, {31'h0, (exp_stall != 0)});
        check({name, " bus_req_at_exit"}, {31'h0, bus_req}, 32'h0);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rv_with_gnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst dout", data_memory_output, 32'h0);
        check("rst stall", {31'h0, stall_mem}, 32'h0);
        check("rst fault", {31'h0, mem_fault}, 32'h0);
        check("rst req", {31'h0, bus_req}, 32'h0);
        check("rst we", {31'h0, bus_we}, 32'h0);
        check("rst wstrb", {28'h0, bus_wstrb}, 32'h0);
        check("rst addr", bus_addr, 32'h0);
        check("rst wdata", bus_wdata, 32'h0);
        @(posedge clk);
        #1;

        //         name     rd    wr    f3     addr          rs2           rdata         gw rw stall flt  dout          baddr         wstrb    wdata
        run_access("lw",    1'b1, 1'b0, F3_W,  32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 0, 3,  1'b0, 32'hDEADBEEF, 32'h0000_0100, 4'b0000, 32'h0);
        run_access("lb",    1'b1, 1'b0, F3_B,  32'h0000_0103, 32'h0,        32'h80FF0000, 2, 1, 6,  1'b0, 32'hFFFFFF80, 32'h0000_0100, 4'b0000, 32'h0);
        rv_with_gnt = 1'b1;
        run_access("lbu",   1'b1, 1'b0, F3_BU, 32'h0000_0103, 32'h0,        32'h80FF0000, 1, 0, 4,  1'b0, 32'h00000080, 32'h0000_0100, 4'b0000, 32'h0);
        run_access("lhu",   1'b1, 1'b0, F3_HU, 32'h0000_0102, 32'h0,        32'h80FF0000, 0, 0, 3,  1'b0, 32'h000080FF, 32'h0000_0100, 4'b0000, 32'h0);
        run_access("lh",    1'b1, 1'b0, F3_H,  32'h0000_0102, 32'h0,        32'h80FF0000, 0, 2, 5,  1'b0, 32'hFFFF80FF, 32'h0000_0100, 4'b0000, 32'h0);
        run_access("lb0",   1'b1, 1'b0, F3_B,  32'h0000_0100, 32'h0,        32'h0000007F, 0, 0, 3,  1'b0, 32'h0000007F, 32'h0000_0100, 4'b0000, 32'h0);
        run_access("sb",    1'b0, 1'b1, F3_B,  32'h0000_0201, 32'h000000AB, 32'h0,        0, 0, 3,  1'b0, 32'h0000007F, 32'h0000_0200, 4'b0010, 32'hABABABAB);
        run_access("sh",    1'b0, 1'b1, F3_H,  32'h0000_0202, 32'h1234CDEF, 32'h0,        1, 1, 5,  1'b0, 32'h0000007F, 32'h0000_0200, 4'b1100, 32'hCDEFCDEF);
        run_access("sw",    1'b0, 1'b1, F3_W,  32'h0000_0204, 32'hCAFEF00D, 32'h0,        0, 0, 3,  1'b0, 32'h0000007F, 32'h0000_0204, 4'b1111, 32'hCAFEF00D);
        run_access("lwmis", 1'b1, 1'b0, F3_W,  32'h0000_0102, 32'h0,        32'h0,        0, 0, 0,  1'b1, 32'h0,        32'h0,         4'b0000, 32'h0);
        run_access("lw2",   1'b1, 1'b0, F3_W,  32'h0000_0300, 32'h0,        32'h11223344, 0, 0, 3,  1'b0, 32'h11223344, 32'h0000_0300, 4'b0000, 32'h0);
        run_access("sbu",   1'b0, 1'b1, F3_BU, 32'h0000_0200, 32'h000000AB, 32'h0,        0, 0, 0,  1'b1, 32'h0,        32'h0,         4'b0000, 32'h0);
        run_access("lf011", 1'b1, 1'b0, 3'b011,32'h0000_0300, 32'h0,        32'h0,        0, 0, 0,  1'b1, 32'h0,        32'h0,         4'b0000, 32'h0);
        run_access("lw3",   1'b1, 1'b0, F3_W,  32'h0000_0300, 32'h0,        32'h55667788, 0, 0, 3,  1'b0, 32'h55667788, 32'h0000_0300, 4'b0000, 32'h0);
        run_access("tmo",   1'b1, 1'b0, F3_W,  32'h0000_0400, 32'h0,        32'h0,     1000, 0, 17, 1'b1, 32'h0,        32'h0000_0400, 4'b0000, 32'h0);
        check("tmo idle stall", {31'h0, stall_mem}, 32'h0);
        run_access("lw4",   1'b1, 1'b0, F3_W,  32'h0000_0300, 32'h0,        32'hCAFE0001, 0, 0, 3,  1'b0, 32'hCAFE0001, 32'h0000_0300, 4'b0000, 32'h0);

        // Reset while waiting for the response, then a stale rvalid.
        gnt_wait    = 0;
        rv_wait     = 1000;
        model_rdata = 32'h0;
        req_q.push_back('{addr: 32'h0000_0300, we: 1'b0, wstrb: 4'b0000, wdata: 32'h0});
        mem_read = 1'b1;
        funct3   = F3_W;
        alu_out  = 32'h0000_0300;
        rs2_data = 32'h0;
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check("rstmid in_wait stall", {31'h0, stall_mem}, 32'h1);
        check("rstmid in_wait req", {31'h0, bus_req}, 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_read = 1'b0;
        done_q.push_back('{fault: 1'b0, dout: 32'h0});
        @(posedge clk);
        #1;
        rst        = 1'b0;
        bus_manual = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus_rvalid = 1'b0;
        bus_manual = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rstmid stall", {31'h0, stall_mem}, 32'h0);
            check("rstmid req", {31'h0, bus_req}, 32'h0);
            check("rstmid dout", data_memory_output, 32'h0);
            check("rstmid fault", {31'h0, mem_fault}, 32'h0);
        end

        check("queues drained", req_q.size() + done_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
